// File: rtl/sdp_ram_init.sv
// sdp_ram_init: simple dual-port RAM with per-byte write enables, selectable
// read-during-write behaviour, 1- or 2-cycle read latency and a hardware
// init sequencer that fills every word with INIT_VAL after reset or clr.
// Optional per-byte even parity is compiled in with `define SDP_RAM_PARITY_EN.
module sdp_ram_init #(
  parameter int unsigned       DWIDTH     = 8,
  parameter int unsigned       AWIDTH     = 3,
  parameter logic [DWIDTH-1:0] INIT_VAL   = '1,
  parameter int unsigned       RDW_MODE   = 0,
  parameter int unsigned       RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  wr_en,
  input  logic [DWIDTH/8-1:0]   wr_be,
  input  logic [AWIDTH-1:0]     wr_addr,
  input  logic [DWIDTH-1:0]     wr_data,
`ifdef SDP_RAM_PARITY_EN
  input  logic                  wr_par_inj,
  output logic [DWIDTH/8-1:0]   rd_par_err,
`endif
  input  logic                  rd_en,
  input  logic [AWIDTH-1:0]     rd_addr,
  output logic [DWIDTH-1:0]     rd_data,
  output logic                  rd_valid
);

  localparam int unsigned NB    = DWIDTH / 8;
  localparam int unsigned DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  // Read payload carries the per-byte parity error flags above the data.
`ifdef SDP_RAM_PARITY_EN
  localparam int unsigned PW = DWIDTH + NB;
`else
  localparam int unsigned PW = DWIDTH;
`endif
  localparam logic [PW-1:0] PAY_RST = PW'(INIT_VAL);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t              r_state;
  logic [AWIDTH-1:0]   r_init_cnt;
  logic                r_busy;

  logic [DWIDTH-1:0]   r_mem [DEPTH];
`ifdef SDP_RAM_PARITY_EN
  logic [NB-1:0]       r_par [DEPTH];
  logic                w_mem_inj;
  logic [NB-1:0]       w_wr_par;
  logic [NB-1:0]       w_rd_par;
  logic [NB-1:0]       w_rd_err;
`endif

  logic                w_ready;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic                w_mem_we;
  logic [AWIDTH-1:0]   w_mem_addr;
  logic [NB-1:0]       w_mem_be;
  logic [DWIDTH-1:0]   w_mem_wdata;
  logic [DWIDTH-1:0]   w_rd_word;
  logic [PW-1:0]       w_rd_pay;
  logic                w_out_vld;
  logic [PW-1:0]       w_out_pay;
  logic [PW-1:0]       r_rd_pay;
  logic                r_rd_valid;

  assign w_ready  = (r_state == ST_READY);
  assign w_wr_acc = w_ready & wr_en & ~clr;
  assign w_rd_acc = w_ready & rd_en & ~clr;

  // Init/ready sequencer: INIT walks every address once, then idles in READY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_init_cnt == LAST_ADDR) begin
            r_state    <= ST_READY;
            r_init_cnt <= '0;
            r_busy     <= 1'b0;
          end else begin
            r_init_cnt <= r_init_cnt + AWIDTH'(1);
          end
        end
        ST_READY: begin
          if (clr) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_busy     <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  assign busy = r_busy;

  // Write-port source select: the sequencer owns the array during INIT.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = wr_addr;
    w_mem_be    = wr_be;
    w_mem_wdata = wr_data;
`ifdef SDP_RAM_PARITY_EN
    w_mem_inj   = 1'b0;
`endif
    if (r_state == ST_INIT) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_init_cnt;
      w_mem_be    = '1;
      w_mem_wdata = INIT_VAL;
    end else if (w_wr_acc) begin
      w_mem_we    = 1'b1;
`ifdef SDP_RAM_PARITY_EN
      w_mem_inj   = wr_par_inj;
`endif
    end
  end

`ifdef SDP_RAM_PARITY_EN
  // Even parity per byte of the word being written, optionally inverted.
  always_comb begin
    w_wr_par = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      w_wr_par[i] = (^w_mem_wdata[8*i +: 8]) ^ w_mem_inj;
    end
  end
`endif

  // Byte-masked array write (array itself is never reset).
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (w_mem_be[i]) begin
          r_mem[w_mem_addr][8*i +: 8] <= w_mem_wdata[8*i +: 8];
`ifdef SDP_RAM_PARITY_EN
          r_par[w_mem_addr][i]        <= w_wr_par[i];
`endif
        end
      end
    end
  end

  // Read word: array contents, or the merged word on a write-first collision.
  always_comb begin
    w_rd_word = r_mem[rd_addr];
`ifdef SDP_RAM_PARITY_EN
    w_rd_par  = r_par[rd_addr];
`endif
    if ((RDW_MODE != 0) && w_wr_acc && (wr_addr == rd_addr)) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          w_rd_word[8*i +: 8] = wr_data[8*i +: 8];
`ifdef SDP_RAM_PARITY_EN
          w_rd_par[i]         = w_wr_par[i];
`endif
        end
      end
    end
  end

`ifdef SDP_RAM_PARITY_EN
  // Per-byte parity check of the word being returned.
  always_comb begin
    w_rd_err = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      w_rd_err[i] = (^w_rd_word[8*i +: 8]) ^ w_rd_par[i];
    end
  end
  assign w_rd_pay = {w_rd_err, w_rd_word};
`else
  assign w_rd_pay = w_rd_word;
`endif

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic          r_s1_vld;
      logic [PW-1:0] r_s1_pay;

      // Extra read stage; its valid is dropped if clr arrives while in flight.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s1_vld <= 1'b0;
          r_s1_pay <= PAY_RST;
        end else begin
          r_s1_vld <= w_rd_acc;
          if (w_rd_acc) begin
            r_s1_pay <= w_rd_pay;
          end
        end
      end

      assign w_out_vld = r_s1_vld & w_ready & ~clr;
      assign w_out_pay = r_s1_pay;
    end else begin : g_lat1
      assign w_out_vld = w_rd_acc;
      assign w_out_pay = w_rd_pay;
    end
  endgenerate

  // Output register: data holds between reads, valid is a one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_pay   <= PAY_RST;
    end else begin
      r_rd_valid <= w_out_vld;
      if (w_out_vld) begin
        r_rd_pay <= w_out_pay;
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_pay[DWIDTH-1:0];
`ifdef SDP_RAM_PARITY_EN
  assign rd_par_err = r_rd_pay[PW-1:DWIDTH];
`endif

endmodule

// File: tb/tb_sdp_ram_init.sv
// Directed bench for sdp_ram_init: instance A is 8-bit, read-first,
// 1-cycle latency; instance B is 16-bit, write-first, 2-cycle latency.
module tb_sdp_ram_init;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       a_clr, a_busy, a_wr_en, a_rd_en, a_rd_valid;
  logic [0:0] a_wr_be;
  logic [2:0] a_wr_addr, a_rd_addr;
  logic [7:0] a_wr_data, a_rd_data;

  logic        b_clr, b_busy, b_wr_en, b_rd_en, b_rd_valid;
  logic [1:0]  b_wr_be;
  logic [2:0]  b_wr_addr, b_rd_addr;
  logic [15:0] b_wr_data, b_rd_data;

`ifdef SDP_RAM_PARITY_EN
  logic       a_wr_par_inj, b_wr_par_inj;
  logic [0:0] a_rd_par_err;
  logic [1:0] b_rd_par_err;
`endif

  int errors = 0;
  int checks = 0;

  sdp_ram_init #(.DWIDTH(8), .AWIDTH(3), .INIT_VAL(8'hFF), .RDW_MODE(0), .RD_LATENCY(1)) u_a (
    .clk(clk), .rst(rst), .clr(a_clr), .busy(a_busy),
    .wr_en(a_wr_en), .wr_be(a_wr_be), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
`ifdef SDP_RAM_PARITY_EN
    .wr_par_inj(a_wr_par_inj), .rd_par_err(a_rd_par_err),
`endif
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid)
  );

  sdp_ram_init #(.DWIDTH(16), .AWIDTH(3), .INIT_VAL(16'hFFFF), .RDW_MODE(1), .RD_LATENCY(2)) u_b (
    .clk(clk), .rst(rst), .clr(b_clr), .busy(b_busy),
    .wr_en(b_wr_en), .wr_be(b_wr_be), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
`ifdef SDP_RAM_PARITY_EN
    .wr_par_inj(b_wr_par_inj), .rd_par_err(b_rd_par_err),
`endif
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [2:0] addr, input logic [7:0] data, input logic be);
    a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data; a_wr_be = be;
    tick;
    a_wr_en = 1'b0;
  endtask

  task automatic a_rd(input logic [2:0] addr);
    a_rd_en = 1'b1; a_rd_addr = addr;
    tick;
    a_rd_en = 1'b0;
  endtask

  task automatic b_write(input logic [2:0] addr, input logic [15:0] data, input logic [1:0] be);
    b_wr_en = 1'b1; b_wr_addr = addr; b_wr_data = data; b_wr_be = be;
    tick;
    b_wr_en = 1'b0;
  endtask

  // Issues a read on B and waits both latency edges.
  task automatic b_rd2(input logic [2:0] addr);
    b_rd_en = 1'b1; b_rd_addr = addr;
    tick;
    b_rd_en = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    int n;
    logic seen;
    #1 rst = 1'b1;
    #2;
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL reset_busy_a: got %b want 1", a_busy); end
    checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_a: got %b want 0", a_rd_valid); end
    checks++; if (a_rd_data !== 8'hFF) begin errors++; $display("FAIL reset_data_a: got %h want ff", a_rd_data); end
    checks++; if (b_rd_data !== 16'hFFFF) begin errors++; $display("FAIL reset_data_b: got %h want ffff", b_rd_data); end
    // requests held high during init must all be ignored
    a_rd_en = 1'b1; a_rd_addr = 3'd0;
    a_wr_en = 1'b1; a_wr_addr = 3'd0; a_wr_data = 8'h00; a_wr_be = 1'b1;
    b_rd_en = 1'b1; b_rd_addr = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    n = 0; seen = 1'b0;
    while (a_busy && n < 20) begin
      tick;
      n++;
      if (a_rd_valid || b_rd_valid) seen = 1'b1;
    end
    a_rd_en = 1'b0; a_wr_en = 1'b0; b_rd_en = 1'b0;
    checks++; if (n != 8) begin errors++; $display("FAIL init_busy_edges_a: got %0d want 8", n); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL init_busy_b: got %b want 0", b_busy); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL init_no_valid: got %b want 0", seen); end
  endtask

  task automatic test_init_fill;
    a_rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_rd_addr = 3'(i);
      tick;
      checks++;
      if (a_rd_valid !== 1'b1 || a_rd_data !== 8'hFF) begin
        errors++; $display("FAIL init_fill_a[%0d]: got v=%b d=%h want v=1 d=ff", i, a_rd_valid, a_rd_data);
      end
    end
    a_rd_en = 1'b0;
    tick;
    checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse_a: got %b want 0", a_rd_valid); end
  endtask

  task automatic test_write_read;
    a_write(3'd3, 8'h5A, 1'b1);
    checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL write_no_valid_a: got %b want 0", a_rd_valid); end
    a_rd(3'd3);
    checks++;
    if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h5A) begin
      errors++; $display("FAIL wr_rd_a: got v=%b d=%h want v=1 d=5a", a_rd_valid, a_rd_data);
    end
    tick;
    checks++;
    if (a_rd_valid !== 1'b0 || a_rd_data !== 8'h5A) begin
      errors++; $display("FAIL hold_a: got v=%b d=%h want v=0 d=5a", a_rd_valid, a_rd_data);
    end
    b_write(3'd3, 16'h005A, 2'b11);
    b_rd_en = 1'b1; b_rd_addr = 3'd3;
    tick;
    b_rd_en = 1'b0;
    checks++; if (b_rd_valid !== 1'b0) begin errors++; $display("FAIL lat2_early_b: got %b want 0", b_rd_valid); end
    tick;
    checks++;
    if (b_rd_valid !== 1'b1 || b_rd_data !== 16'h005A) begin
      errors++; $display("FAIL lat2_b: got v=%b d=%h want v=1 d=005a", b_rd_valid, b_rd_data);
    end
  endtask

  task automatic test_byte_enable;
    b_write(3'd2, 16'h1234, 2'b11);
    b_write(3'd2, 16'hABCD, 2'b01);
    b_rd2(3'd2);
    checks++;
    if (b_rd_valid !== 1'b1 || b_rd_data !== 16'h12CD) begin
      errors++; $display("FAIL byte_en_b: got v=%b d=%h want v=1 d=12cd", b_rd_valid, b_rd_data);
    end
    a_write(3'd3, 8'h00, 1'b0);
    a_rd(3'd3);
    checks++; if (a_rd_data !== 8'h5A) begin errors++; $display("FAIL be_zero_a: got %h want 5a", a_rd_data); end
  endtask

  task automatic test_collision;
    a_write(3'd5, 8'h11, 1'b1);
    a_wr_en = 1'b1; a_wr_addr = 3'd5; a_wr_data = 8'h77; a_wr_be = 1'b1;
    a_rd_en = 1'b1; a_rd_addr = 3'd5;
    tick;
    a_wr_en = 1'b0; a_rd_en = 1'b0;
    checks++; if (a_rd_data !== 8'h11) begin errors++; $display("FAIL rdw_first_a: got %h want 11", a_rd_data); end
    a_rd(3'd5);
    checks++; if (a_rd_data !== 8'h77) begin errors++; $display("FAIL rdw_after_a: got %h want 77", a_rd_data); end
    a_wr_en = 1'b1; a_wr_addr = 3'd6; a_wr_data = 8'h33; a_wr_be = 1'b1;
    a_rd_en = 1'b1; a_rd_addr = 3'd3;
    tick;
    a_wr_en = 1'b0; a_rd_en = 1'b0;
    checks++; if (a_rd_data !== 8'h5A) begin errors++; $display("FAIL diff_addr_a: got %h want 5a", a_rd_data); end
    a_rd(3'd6);
    checks++; if (a_rd_data !== 8'h33) begin errors++; $display("FAIL diff_addr_wr_a: got %h want 33", a_rd_data); end
    b_write(3'd5, 16'h1111, 2'b11);
    b_wr_en = 1'b1; b_wr_addr = 3'd5; b_wr_data = 16'h7777; b_wr_be = 2'b01;
    b_rd_en = 1'b1; b_rd_addr = 3'd5;
    tick;
    b_wr_en = 1'b0; b_rd_en = 1'b0;
    tick;
    checks++;
    if (b_rd_valid !== 1'b1 || b_rd_data !== 16'h1177) begin
      errors++; $display("FAIL rdw_merge_b: got v=%b d=%h want v=1 d=1177", b_rd_valid, b_rd_data);
    end
  endtask

  task automatic test_back_to_back;
    b_rd_en = 1'b1; b_rd_addr = 3'd0;
    tick;
    checks++; if (b_rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_first_b: got %b want 0", b_rd_valid); end
    b_rd_addr = 3'd1;
    tick;
    checks++;
    if (b_rd_valid !== 1'b1 || b_rd_data !== 16'hFFFF) begin
      errors++; $display("FAIL b2b_0_b: got v=%b d=%h want v=1 d=ffff", b_rd_valid, b_rd_data);
    end
    b_rd_addr = 3'd2;
    tick;
    checks++;
    if (b_rd_valid !== 1'b1 || b_rd_data !== 16'hFFFF) begin
      errors++; $display("FAIL b2b_1_b: got v=%b d=%h want v=1 d=ffff", b_rd_valid, b_rd_data);
    end
    b_rd_en = 1'b0;
    tick;
    checks++;
    if (b_rd_valid !== 1'b1 || b_rd_data !== 16'h12CD) begin
      errors++; $display("FAIL b2b_2_b: got v=%b d=%h want v=1 d=12cd", b_rd_valid, b_rd_data);
    end
    tick;
    checks++; if (b_rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_b: got %b want 0", b_rd_valid); end
  endtask

  task automatic test_clr;
    int n;
    logic seen;
    b_rd_en = 1'b1; b_rd_addr = 3'd2;
    tick;
    b_rd_en = 1'b0; b_clr = 1'b1;
    tick;
    b_clr = 1'b0;
    checks++;
    if (b_rd_valid !== 1'b0 || b_busy !== 1'b1) begin
      errors++; $display("FAIL clr_flush_b: got v=%b busy=%b want v=0 busy=1", b_rd_valid, b_busy);
    end
    n = 0; seen = 1'b0;
    while (b_busy && n < 20) begin
      tick; n++;
      if (b_rd_valid) seen = 1'b1;
    end
    checks++; if (n != 8 || seen) begin errors++; $display("FAIL clr_init_b: got edges=%0d valid=%b want 8 0", n, seen); end
    b_rd2(3'd2);
    checks++; if (b_rd_data !== 16'hFFFF) begin errors++; $display("FAIL clr_refill_b: got %h want ffff", b_rd_data); end
    a_clr = 1'b1;
    a_rd_en = 1'b1; a_rd_addr = 3'd3;
    a_wr_en = 1'b1; a_wr_addr = 3'd4; a_wr_data = 8'h99; a_wr_be = 1'b1;
    tick;
    a_clr = 1'b0; a_rd_en = 1'b0; a_wr_en = 1'b0;
    checks++;
    if (a_rd_valid !== 1'b0 || a_busy !== 1'b1) begin
      errors++; $display("FAIL clr_ignore_a: got v=%b busy=%b want v=0 busy=1", a_rd_valid, a_busy);
    end
    n = 0;
    while (a_busy && n < 20) begin tick; n++; end
    checks++; if (n != 8) begin errors++; $display("FAIL clr_edges_a: got %0d want 8", n); end
    a_rd(3'd3);
    checks++; if (a_rd_data !== 8'hFF) begin errors++; $display("FAIL clr_refill_a: got %h want ff", a_rd_data); end
  endtask

  task automatic test_rst_mid_init;
    int n;
    a_write(3'd1, 8'h42, 1'b1);
    a_rd(3'd1);
    checks++; if (a_rd_data !== 8'h42) begin errors++; $display("FAIL pre_rst_a: got %h want 42", a_rd_data); end
    a_clr = 1'b1;
    tick;
    a_clr = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (a_busy !== 1'b1 || a_rd_data !== 8'hFF) begin
      errors++; $display("FAIL mid_rst_a: got busy=%b d=%h want 1 ff", a_busy, a_rd_data);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (a_busy && n < 20) begin tick; n++; end
    checks++; if (n != 8) begin errors++; $display("FAIL mid_rst_edges_a: got %0d want 8", n); end
    a_rd(3'd1);
    checks++; if (a_rd_data !== 8'hFF) begin errors++; $display("FAIL mid_rst_fill_a: got %h want ff", a_rd_data); end
  endtask

`ifdef SDP_RAM_PARITY_EN
  task automatic test_parity;
    a_wr_par_inj = 1'b1;
    a_write(3'd1, 8'h0F, 1'b1);
    a_wr_par_inj = 1'b0;
    a_rd(3'd1);
    checks++;
    if (a_rd_par_err !== 1'b1 || a_rd_data !== 8'h0F) begin
      errors++; $display("FAIL par_inj_a: got err=%b d=%h want 1 0f", a_rd_par_err, a_rd_data);
    end
    a_write(3'd2, 8'h0F, 1'b1);
    a_rd(3'd2);
    checks++; if (a_rd_par_err !== 1'b0) begin errors++; $display("FAIL par_ok_a: got %b want 0", a_rd_par_err); end
    b_wr_par_inj = 1'b1;
    b_write(3'd6, 16'h0F0F, 2'b01);
    b_wr_par_inj = 1'b0;
    b_rd2(3'd6);
    checks++;
    if (b_rd_par_err !== 2'b01 || b_rd_data !== 16'hFF0F) begin
      errors++; $display("FAIL par_inj_b: got err=%b d=%h want 01 ff0f", b_rd_par_err, b_rd_data);
    end
  endtask
`endif

  initial begin
    a_clr = 1'b0; a_wr_en = 1'b0; a_wr_be = '0; a_wr_addr = '0; a_wr_data = '0;
    a_rd_en = 1'b0; a_rd_addr = '0;
    b_clr = 1'b0; b_wr_en = 1'b0; b_wr_be = '0; b_wr_addr = '0; b_wr_data = '0;
    b_rd_en = 1'b0; b_rd_addr = '0;
`ifdef SDP_RAM_PARITY_EN
    a_wr_par_inj = 1'b0; b_wr_par_inj = 1'b0;
`endif
    test_reset;
    test_init_fill;
    test_write_read;
    test_byte_enable;
    test_collision;
    test_back_to_back;
    test_clr;
    test_rst_mid_init;
`ifdef SDP_RAM_PARITY_EN
    test_parity;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdp_ram_init.md
Name: sdp_ram_init

Overview:
- Parametrised simple dual-port RAM; successor to the team's single-port RAM.
- One write port and one independent read port, both in one clock domain.
- Per-byte write enables, selectable read-during-write mode, 1- or 2-cycle read latency.
- Hardware init sequencer fills every word with INIT_VAL after reset or on software clear; used as a buffer store inside the dual-rate RAM subsystem.

Parameters:
DWIDTH, 8, data width in bits; must be a multiple of 8
AWIDTH, 3, address width; DEPTH = 2**AWIDTH words
INIT_VAL, all-ones, value written to every word during init
RDW_MODE, 0, same-address read/write collision: 0 = read-first (old data), 1 = write-first (new data)
RD_LATENCY, 1, cycles from accepted read to rd_valid/rd_data; legal values 1 or 2

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous request to re-run the init sequence
busy  out  1  high while the init sequence runs; requests ignored
wr_en  in  1  write request
wr_be  in  DWIDTH/8  byte enables; bit i covers data bits [8i+7:8i]
wr_addr  in  AWIDTH  write address
wr_data  in  DWIDTH  write data
rd_en  in  1  read request
rd_addr  in  AWIDTH  read address
rd_data  out  DWIDTH  read data; holds its last value between reads
rd_valid  out  1  one-cycle pulse marking new rd_data

Behaviour:
- Reset (rst high, asynchronous):
  - FSM goes to INIT; init counter = 0; busy = 1.
  - rd_data = INIT_VAL; rd_valid = 0; read pipeline valid bits = 0.
  - Memory array is not reset asynchronously.
- FSM states: INIT, READY.
- INIT:
  - Each edge writes INIT_VAL to mem[init counter], then increments the counter.
  - Edge k after rst release writes address k-1.
  - The edge that writes address DEPTH-1 moves the FSM to READY and drives busy = 0.
  - busy is therefore high for exactly DEPTH edges.
- In INIT, wr_en, rd_en and clr are ignored. No rd_valid is produced.
- READY + clr: next edge goes to INIT with counter = 0 and busy = 1; in-flight reads are flushed (rd_valid stays 0). Any wr_en/rd_en in the same cycle as clr is ignored.
- Write (READY, wr_en, no clr): on the edge, only bytes with wr_be[i] = 1 are updated. wr_be = 0 is a legal no-op.
- Read (READY, rd_en, no clr):
  - RD_LATENCY = 1: rd_data = mem[rd_addr] and rd_valid = 1 after the next edge.
  - RD_LATENCY = 2: one extra output register stage. Back-to-back reads give one result per cycle.
- Collision (wr_en and rd_en, same address, same cycle):
  - RDW_MODE = 0: rd_data returns the pre-write word.
  - RDW_MODE = 1: rd_data returns the merged word (new bytes where wr_be = 1, old bytes elsewhere).
  - Different addresses: fully independent.
- Address wrap: the init counter stops at DEPTH-1 and never wraps into READY writes. All addresses are in range by construction.
- rst mid-init or mid-read: abort immediately; sequence restarts from address 0 after release.

Optional Feature:
- Macro SDP_RAM_PARITY_EN.
- When defined:
  - Each word stores one even-parity bit per byte.
  - Added input wr_par_inj (1 bit): when high with an accepted write, stored parity is inverted for every enabled byte.
  - Added output rd_par_err (DWIDTH/8 bits): per-byte mismatch, aligned with rd_valid; reset value 0.
  - Init writes correct parity.
- When undefined: no parity storage, and neither port exists.

Test Plan:
- Reset then release, DWIDTH=8, AWIDTH=3 -> busy high for exactly 8 edges; afterwards, reads of addresses 0..7 all return 0xFF with rd_valid pulses.
- Write 0x5A to address 3, then read address 3 (RD_LATENCY=1) -> rd_data = 0x5A and rd_valid = 1 one edge after the read. With RD_LATENCY=2 -> same result two edges after the read.
- DWIDTH=16: write 0x1234 with be=11 to address 2, then write 0xABCD with be=01 to address 2 -> read returns 0x12CD.
- Same-cycle write 0x77 and read at address 5 holding 0x11 -> RDW_MODE=0 returns 0x11; RDW_MODE=1 returns 0x77.
- clr asserted with a read in flight -> no rd_valid; busy high for 8 edges; the previously written address then reads 0xFF. rst pulsed at init edge 4 -> busy high for a full 8 edges after release.
- SDP_RAM_PARITY_EN: write 0x0F with wr_par_inj=1, then read -> rd_par_err = 1. A normal write followed by a read -> rd_par_err = 0.
